// File: rtl/fifo_write_arbiter.sv
// Round-robin burst arbiter that shares one FIFO write port among numReq producers.
// Optional macro FIXED_PRIORITY_EN: IDLE arbitration always picks the lowest-indexed requester.
module fifo_write_arbiter #(
  parameter int dataWidth = 8,
  parameter int numReq    = 4,
  parameter int burstLen  = 4
) (
  input  logic                          clkIn,
  input  logic                          rstIn,
  input  logic [numReq-1:0]             reqIn,
  input  logic [numReq*dataWidth-1:0]   dataIn,
  input  logic                          fifoFullIn,
  output logic [numReq-1:0]             grantOut,
  output logic [numReq-1:0]             ackOut,
  output logic                          writeEnableOut,
  output logic [dataWidth-1:0]          dataOut,
  output logic [$clog2(numReq)-1:0]     ownerOut,
  output logic                          busyOut
);
  localparam int OW = $clog2(numReq);
  localparam int CW = $clog2(burstLen + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(burstLen - 1);

  // Handshake: a word moves when the owner requests and the FIFO is not full;
  // ackOut/writeEnableOut pulse in that same cycle and the producer advances after it.
  typedef enum logic {ST_IDLE = 1'b0, ST_SERVE = 1'b1} state_e;

  state_e            state_q, state_d;
  logic [OW-1:0]     owner_q, owner_d;
  logic [numReq-1:0] grant_q, grant_d;
  logic              busy_q, busy_d;
  logic [CW-1:0]     count_q, count_d;
  logic [OW-1:0]     pick;
  logic              pick_vld;
  logic              accept;
`ifndef FIXED_PRIORITY_EN
  logic [OW-1:0]     ptr_q, ptr_d;
`endif

  // Later loop iterations override earlier ones, so the nearest candidate wins.
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
`ifdef FIXED_PRIORITY_EN
    for (int i = numReq - 1; i >= 0; i--) begin
      if (reqIn[i]) begin
        pick     = OW'(i);
        pick_vld = 1'b1;
      end
    end
`else
    for (int k = numReq; k >= 1; k--) begin
      if (reqIn[(int'(ptr_q) + k) % numReq]) begin
        pick     = OW'((int'(ptr_q) + k) % numReq);
        pick_vld = 1'b1;
      end
    end
`endif
  end

  assign accept         = (state_q == ST_SERVE) && reqIn[owner_q] && !fifoFullIn;
  assign writeEnableOut = accept;
  assign dataOut        = dataIn[owner_q*dataWidth +: dataWidth];
  assign grantOut       = grant_q;
  assign ownerOut       = owner_q;
  assign busyOut        = busy_q;

  always_comb begin
    ackOut          = '0;
    ackOut[owner_q] = accept;
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    grant_d = grant_q;
    busy_d  = busy_q;
    count_d = count_q;
`ifndef FIXED_PRIORITY_EN
    ptr_d   = ptr_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (pick_vld) begin
          state_d       = ST_SERVE;
          owner_d       = pick;
          grant_d       = '0;
          grant_d[pick] = 1'b1;
          busy_d        = 1'b1;
          count_d       = '0;
        end
      end
      ST_SERVE: begin
        // A stalled word neither counts nor releases; only a dropped request or a full burst ends ownership.
        if (!reqIn[owner_q] || (accept && count_q == LAST_CNT)) begin
          state_d = ST_IDLE;
          grant_d = '0;
          busy_d  = 1'b0;
`ifndef FIXED_PRIORITY_EN
          ptr_d   = owner_q;
`endif
        end else if (accept) begin
          count_d = count_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clkIn) begin
    if (!rstIn) begin
      state_q <= ST_IDLE;
      owner_q <= '0;
      grant_q <= '0;
      busy_q  <= 1'b0;
      count_q <= '0;
`ifndef FIXED_PRIORITY_EN
      ptr_q   <= OW'(numReq - 1);
`endif
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      grant_q <= grant_d;
      busy_q  <= busy_d;
      count_q <= count_d;
`ifndef FIXED_PRIORITY_EN
      ptr_q   <= ptr_d;
`endif
    end
  end
endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Bench for fifo_write_arbiter: producer queues feed the DUT, a transaction-level model predicts
// ownership and writes each cycle, and a write scoreboard checks the FIFO-side word stream.
module tb_fifo_write_arbiter;
  localparam int DW = 8;
  localparam int NR = 4;
  localparam int BL = 4;
  localparam int OW = 2;

  logic              clkIn = 1'b0;
  logic              rstIn;
  logic              fifoFullIn;
  logic [NR-1:0]     reqIn;
  logic [NR*DW-1:0]  dataIn;
  logic [NR-1:0]     grantOut;
  logic [NR-1:0]     ackOut;
  logic              writeEnableOut;
  logic [DW-1:0]     dataOut;
  logic [OW-1:0]     ownerOut;
  logic              busyOut;

  fifo_write_arbiter #(.dataWidth(DW), .numReq(NR), .burstLen(BL)) dut (
    .clkIn(clkIn), .rstIn(rstIn), .reqIn(reqIn), .dataIn(dataIn), .fifoFullIn(fifoFullIn),
    .grantOut(grantOut), .ackOut(ackOut), .writeEnableOut(writeEnableOut), .dataOut(dataOut),
    .ownerOut(ownerOut), .busyOut(busyOut)
  );

  always #5 clkIn = ~clkIn;

  int total = 0;
  int bad   = 0;

  // Producer word queues as ring buffers; a producer requests while it holds a word and is enabled.
  logic [DW-1:0] pdata [NR][256];
  int            prd [NR];
  int            pwr [NR];
  logic [NR-1:0] hold_en;

  // Reference model: who owns the port (-1 = nobody), words moved in this grant, last producer served.
  int m_owner;
  int m_done;
  int m_last;

  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] wlog_d[$];
  int            dut_glog[$];
  logic          prev_busy;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int arb_pick(input logic [NR-1:0] r, input int last);
`ifdef FIXED_PRIORITY_EN
    for (int i = 0; i < NR; i++) if (r[i]) return i;
`else
    for (int k = 1; k <= NR; k++) if (r[(last + k) % NR]) return (last + k) % NR;
`endif
    return -1;
  endfunction

  function automatic logic [NR-1:0] cur_req();
    logic [NR-1:0] r;
    for (int i = 0; i < NR; i++) r[i] = hold_en[i] && (prd[i] < pwr[i]);
    return r;
  endfunction

  function automatic bit pending();
    for (int i = 0; i < NR; i++) if (prd[i] < pwr[i]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic push_word(input int p, input logic [DW-1:0] d);
    pdata[p][pwr[p] % 256] = d;
    pwr[p]++;
  endtask

  task automatic clear_producers();
    for (int i = 0; i < NR; i++) begin
      prd[i] = 0;
      pwr[i] = 0;
    end
  endtask

  // One clock: drive at negedge, compare just after, advance the model at posedge.
  task automatic cycle(input logic rst_n, input logic full);
    logic [NR-1:0] r;
    bit            busy;
    bit            acc;
    logic [DW-1:0] e;
    @(negedge clkIn);
    r          = cur_req();
    rstIn      = rst_n;
    fifoFullIn = full;
    reqIn      = r;
    for (int i = 0; i < NR; i++)
      dataIn[i*DW +: DW] = (prd[i] < pwr[i]) ? pdata[i][prd[i] % 256] : DW'($urandom);
    #1;
    busy = (m_owner >= 0);
    acc  = busy && r[m_owner] && !full;
    check("busy", busyOut, busy);
    check("grant", grantOut, busy ? (32'd1 << m_owner) : 32'd0);
    check("wr_en", writeEnableOut, acc);
    check("ack", ackOut, acc ? (32'd1 << m_owner) : 32'd0);
    check("wr_while_full", writeEnableOut & fifoFullIn, 0);
    if (busy) begin
      check("owner", ownerOut, m_owner);
      check("data_mux", dataOut, dataIn[m_owner*DW +: DW]);
    end
    if (acc) exp_q.push_back(pdata[m_owner][prd[m_owner] % 256]);
    if (writeEnableOut === 1'b1) begin
      if (exp_q.size() == 0) check("unexpected_write", 1, 0);
      else begin
        e = exp_q.pop_front();
        check("wr_data", dataOut, e);
        wlog_d.push_back(dataOut);
      end
    end
    if (busyOut === 1'b1 && prev_busy !== 1'b1) dut_glog.push_back(int'(ownerOut));
    prev_busy = busyOut;
    @(posedge clkIn);
    if (acc) begin
      prd[m_owner]++;
      m_done++;
    end
    if (!rst_n) begin
      m_owner = -1;
      m_done  = 0;
      m_last  = NR - 1;
    end else if (!busy) begin
      m_owner = arb_pick(r, m_last);
      m_done  = 0;
    end else if (!r[m_owner] || m_done == BL) begin
      m_last  = m_owner;
      m_owner = -1;
    end
  endtask

  task automatic run_until_idle(input int budget);
    int n = 0;
    while ((pending() || m_owner >= 0) && n < budget) begin
      cycle(1'b1, 1'b0);
      n++;
    end
    if (pending() || m_owner >= 0) check("drain_timeout", 1, 0);
  endtask

  task automatic reset_phase();
    hold_en = '0;
    clear_producers();
    cycle(1'b0, 1'b0);
    cycle(1'b0, 1'b0);
    #1;
    check("rst_owner", ownerOut, 0);
    check("rst_busy", busyOut, 0);
    check("rst_grant", grantOut, 0);
    wlog_d.delete();
    dut_glog.delete();
  endtask

  initial begin
    int n;
    int stall_left;
    bit stalled;
    int exp_order [5];
    exp_order = '{0, 1, 2, 3, 0};
    rstIn = 1'b0; fifoFullIn = 1'b0; reqIn = '0; dataIn = '0;
    hold_en = '0; prev_busy = 1'b0;
    clear_producers();
    m_owner = -1; m_done = 0; m_last = NR - 1;
    repeat (2) @(posedge clkIn);

    // Single producer: six words through two bursts.
    reset_phase();
    hold_en = 4'b0100;
    for (int k = 0; k < 6; k++) push_word(2, DW'(8'h20 + k));
    run_until_idle(40);
    check("single_count", wlog_d.size(), 6);
    for (int k = 0; k < 6 && k < wlog_d.size(); k++) check("single_word", wlog_d[k], 8'h20 + k);
    check("single_grants", dut_glog.size(), 2);

`ifndef FIXED_PRIORITY_EN
    // All producers busy: round-robin order from reset.
    reset_phase();
    hold_en = 4'b1111;
    for (int i = 0; i < NR; i++) for (int k = 0; k < 8; k++) push_word(i, DW'(8'h40 + i*16 + k));
    repeat (25) cycle(1'b1, 1'b0);
    check("rr_grants", dut_glog.size() >= 5, 1);
    for (int k = 0; k < 5 && k < dut_glog.size(); k++) check("rr_order", dut_glog[k], exp_order[k]);
    check("rr_words", wlog_d.size(), 20);
    run_until_idle(100);
`else
    // Fixed priority: producer 0 keeps winning while it requests.
    reset_phase();
    hold_en = 4'b0011;
    for (int k = 0; k < 16; k++) push_word(0, DW'(8'h60 + k));
    for (int k = 0; k < 8; k++) push_word(1, DW'(8'h80 + k));
    repeat (19) cycle(1'b1, 1'b0);
    check("fp_grants", dut_glog.size() >= 3, 1);
    for (int k = 0; k < dut_glog.size(); k++) check("fp_owner", dut_glog[k], 0);
    run_until_idle(100);
`endif

    // Full stall after the second write of a burst.
    reset_phase();
    hold_en = 4'b0001;
    for (int k = 0; k < 4; k++) push_word(0, DW'(8'hA0 + k));
    stall_left = 0; stalled = 1'b0; n = 0;
    while ((pending() || m_owner >= 0) && n < 40) begin
      if (wlog_d.size() == 2 && !stalled) begin
        stall_left = 3;
        stalled    = 1'b1;
      end
      cycle(1'b1, stall_left > 0);
      if (stall_left > 0) stall_left--;
      n++;
    end
    check("stall_total", wlog_d.size(), 4);
    check("stall_one_grant", dut_glog.size(), 1);

    // Early drop: producer 1 stops after two words, producer 3 follows.
    reset_phase();
    hold_en = 4'b1010;
    push_word(1, 8'hB0); push_word(1, 8'hB1);
    for (int k = 0; k < 4; k++) push_word(3, DW'(8'hC0 + k));
    run_until_idle(40);
    check("drop_grants", dut_glog.size(), 2);
    if (dut_glog.size() == 2) begin
      check("drop_first", dut_glog[0], 1);
      check("drop_second", dut_glog[1], 3);
    end

    // Reset in the middle of producer 2's burst.
    reset_phase();
    hold_en = 4'b0100;
    for (int k = 0; k < 6; k++) push_word(2, DW'(8'hD0 + k));
    n = 0;
    while (wlog_d.size() < 2 && n < 20) begin
      cycle(1'b1, 1'b0);
      n++;
    end
    check("mid_rst_reached", wlog_d.size(), 2);
    cycle(1'b0, 1'b0);
    prd[2] = pwr[2];
    hold_en = 4'b1001;
    for (int k = 0; k < 4; k++) begin
      push_word(0, DW'(8'hE0 + k));
      push_word(3, DW'(8'hF0 + k));
    end
    dut_glog.delete();
    cycle(1'b1, 1'b0);
    check("mid_rst_idle", busyOut, 0);
    run_until_idle(60);
    check("mid_rst_regrants", dut_glog.size() >= 1, 1);
    if (dut_glog.size() >= 1) check("mid_rst_first", dut_glog[0], 0);

    // Randomized traffic with stalls, request gaps and occasional resets.
    reset_phase();
    hold_en = $urandom_range(0, 15);
    for (int c = 0; c < 800; c++) begin
      for (int i = 0; i < NR; i++) begin
        if (pwr[i] - prd[i] < 6 && $urandom_range(0, 2) == 0) push_word(i, DW'($urandom));
        if ($urandom_range(0, 7) == 0) hold_en[i] = ~hold_en[i];
      end
      cycle($urandom_range(0, 99) != 0, $urandom_range(0, 3) == 0);
    end
    hold_en = '1;
    run_until_idle(400);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fifo_write_arbiter.md
Name: fifo_write_arbiter

Overview:
- Round-robin arbiter that shares the write port of one FIFOTop instance among numReq producers in the write-clock domain.
- Grants one producer at a time for a bounded burst of up to burstLen words and muxes that producer's data onto the FIFO write port.
- Honours the FIFO full flag; a stalled word is never dropped and is not counted toward the burst.

Parameters:
- dataWidth, 8, width of each data word; must match the FIFOTop dataWidth.
- numReq, 4, number of producers, 2..16.
- burstLen, 4, maximum number of accepted words per grant, 1..256.

Ports:
- clkIn  input  1  single clock; connects to the FIFO writeClkIn.
- rstIn  input  1  reset, synchronous and active-low.
- reqIn  input  numReq  per-producer request; bit i is high while producer i holds a valid word.
- dataIn  input  numReq*dataWidth  producer words; slice i is [i*dataWidth +: dataWidth].
- fifoFullIn  input  1  FIFO full flag (fifoFullOut of FIFOTop).
- grantOut  output  numReq  one-hot owner indication; all zero when no producer owns the port.
- ackOut  output  numReq  one-hot word-accepted strobe; the producer advances its data on the cycle after ackOut.
- writeEnableOut  output  1  drives FIFO writeEnableIn.
- dataOut  output  dataWidth  drives FIFO dataIn.
- ownerOut  output  $clog2(numReq)  index of the current owner; valid only while busyOut=1.
- busyOut  output  1  high while in SERVE.

Behaviour:
- Reset (rstIn=0 at posedge):
  - state=IDLE, grantOut=0, ownerOut=0, busyOut=0, burst count=0.
  - last-grant pointer = numReq-1, so producer 0 has first priority.
  - writeEnableOut=0 and ackOut=0 (both are gated by SERVE).
  - A reset mid-burst abandons the burst immediately. Words already written stay in the FIFO.
- IDLE:
  - If reqIn is nonzero, select the first set bit searching upward from pointer+1, wrapping modulo numReq.
  - Register the selected index as owner, set the matching grantOut bit, set busyOut=1, clear count, go to SERVE.
  - The grant is visible the cycle after the request is sampled (1-cycle arbitration latency).
  - If reqIn is zero, stay in IDLE.
- SERVE, combinational outputs:
  - accept = reqIn[owner] & ~fifoFullIn.
  - writeEnableOut = accept.
  - dataOut = dataIn slice [owner]; it is driven with the owner slice even when accept=0.
  - ackOut[owner] = accept; all other ackOut bits are 0.
- SERVE, registered updates:
  - On accept, count increments.
  - Release when accept occurs with count==burstLen-1, or when reqIn[owner]==0. A drop of the request ends the burst even if count<burstLen-1.
  - On release: pointer=owner, grantOut=0, busyOut=0, next state IDLE.
- Full stall:
  - fifoFullIn=1 holds writeEnableOut=0. count freezes and ownership is kept indefinitely.
- Burst spacing:
  - Exactly one IDLE cycle separates consecutive bursts.
  - Sustained throughput is therefore burstLen/(burstLen+1) with all producers busy.
- Fairness: after a producer's burst, every other requesting producer is served once before it is served again.
- Non-owner requests are ignored until the next IDLE arbitration.
- count width is $clog2(burstLen+1). With burstLen=1 every accept releases.
- The block never asserts writeEnableOut while fifoFullIn=1. FIFO overflow is impossible through this block.

Optional Feature:
- Macro: FIXED_PRIORITY_EN.
- Defined: IDLE arbitration always selects the lowest-indexed set bit of reqIn. The pointer is not used; its register may be removed. Starvation of higher indices is permitted.
- Undefined: the round-robin behaviour described above.
- All other behaviour (bursts, stalls, reset) is identical in both builds.

Test Plan (numReq=4, burstLen=4, dataWidth=8):
- Single producer: reqIn=0100 held for 6 words, data 0x20..0x25, no full.
  - Expect grantOut=0100 one cycle later and 4 writes 0x20..0x23 on consecutive cycles.
  - Then 1 IDLE cycle, regrant to 2, writes 0x24,0x25; drop req, then grantOut=0.
- All producers: reqIn=1111 continuous from reset.
  - Expect grant order 0,1,2,3,0, each with exactly 4 writes and 1 idle cycle between bursts.
  - FIFOTop read side drains in the same order.
- Full stall: fifoFullIn=1 for 3 cycles after the 2nd write of a burst.
  - Expect writeEnableOut=0 and ackOut=0 for those 3 cycles, with grant held.
  - Then the remaining 2 words are written and the burst totals exactly 4.
- Early drop: producer 1 drops reqIn[1] after 2 acks while reqIn=1010.
  - Expect release, one IDLE cycle, then grantOut=1000 (producer 3).
- Mid-burst reset: rstIn=0 for 1 cycle during producer 2's burst.
  - Next cycle expect grantOut=0, busyOut=0, writeEnableOut=0.
  - After release with reqIn=1001, expect the grant to go to producer 0.
- FIXED_PRIORITY_EN defined, reqIn=0011 continuous: expect every burst granted to producer 0 and producer 1 never granted.
